// File: rtl/fht_but_feeder.sv
// rtl/fht_but_feeder.sv - FHT stage sequencer: read/ROM address generation, operand alignment, write-back addressing
module fht_but_feeder #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12,
  parameter int A_BIT = 8
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic [A_BIT-1:0]   iSTAGE,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oBANK,
  output logic [A_BIT-1:0]   oRD_ADDR_0,
  output logic [A_BIT-1:0]   oRD_ADDR_1,
  output logic [A_BIT-1:0]   oRD_ADDR_2,
  output logic [A_BIT-2:0]   oROM_ADDR,
  input  logic [D_BIT-1:0]   iRD_DATA_0,
  input  logic [D_BIT-1:0]   iRD_DATA_1,
  input  logic [D_BIT-1:0]   iRD_DATA_2,
  input  logic [W_BIT-1:0]   iROM_SIN,
  input  logic [W_BIT-1:0]   iROM_COS,
  output logic [D_BIT-1:0]   oX_0,
  output logic [D_BIT-1:0]   oX_1,
  output logic [D_BIT-1:0]   oX_2,
  output logic [W_BIT-1:0]   oSIN,
  output logic [W_BIT-1:0]   oCOS,
  output logic               oWR_EN,
  output logic [A_BIT-1:0]   oWR_ADDR_0,
  output logic [A_BIT-1:0]   oWR_ADDR_1
);

  localparam int J_BIT = A_BIT - 1;
  localparam logic [J_BIT-1:0] J_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                   state_q;
  logic [J_BIT-1:0]         j_q;
  logic [1:0]               flush_q;
  logic [A_BIT-1:0]         stage_q;
  logic [2:0]               v_q;
  logic [D_BIT-1:0]         x0_q;
  logic [2:0][A_BIT-1:0]    wa0_q;
  logic [2:0][A_BIT-1:0]    wa1_q;

  logic [J_BIT-1:0]         j_d;
  logic [A_BIT-1:0]         s_d;
  logic [A_BIT-1:0]         jw, h, b, k;
  logic [A_BIT-1:0]         x0_d, x1_d, x2_d;
  logic [J_BIT-1:0]         rom_d;
  logic                     start_ok;

  // Address of the next butterfly: j=0 with the requested stage when idle, else j+1.
  always_comb begin
    j_d      = (state_q == S_IDLE) ? '0 : j_q + 1'b1;
    s_d      = (state_q == S_IDLE) ? iSTAGE : stage_q;
    jw       = {1'b0, j_d};
    h        = A_BIT'(1) << s_d;
    b        = ((jw >> s_d) << s_d) << 1;
    k        = jw & (h - 1'b1);
    x0_d     = b + k;
    x1_d     = b + k + h;
    x2_d     = b + h + ((h - k) & (h - 1'b1));
    rom_d    = J_BIT'(k) << (A_BIT'(J_BIT) - s_d);
    start_ok = iSTART && (iSTAGE < A_BIT'(A_BIT));
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      flush_q    <= '0;
      stage_q    <= '0;
      v_q        <= '0;
      x0_q       <= '0;
      wa0_q      <= '0;
      wa1_q      <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oBANK      <= 1'b0;
      oRD_ADDR_0 <= '0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oROM_ADDR  <= '0;
      oX_0       <= '0;
      oX_1       <= '0;
      oX_2       <= '0;
      oSIN       <= '0;
      oCOS       <= '0;
      oWR_EN     <= 1'b0;
      oWR_ADDR_0 <= '0;
      oWR_ADDR_1 <= '0;
    end else begin
      // v_q[0]: RAM/ROM data valid; v_q[1]: x1/x2/twiddle valid; v_q[2]: x0 valid.
      v_q    <= {v_q[1:0], state_q == S_RUN};
      wa0_q  <= {wa0_q[1:0], oRD_ADDR_0};
      wa1_q  <= {wa1_q[1:0], oRD_ADDR_1};
      oWR_EN <= v_q[2];
      if (v_q[2]) begin
        oWR_ADDR_0 <= wa0_q[2];
        oWR_ADDR_1 <= wa1_q[2];
      end
      if (v_q[0]) begin
        oX_1 <= iRD_DATA_1;
        oX_2 <= iRD_DATA_2;
        oSIN <= iROM_SIN;
        oCOS <= iROM_COS;
        x0_q <= iRD_DATA_0;
      end
      // x0 lags by one stage because the butterfly registers the product before adding it.
      if (v_q[1]) begin
        oX_0 <= x0_q;
      end

      case (state_q)
        S_IDLE: begin
          oDONE <= 1'b0;
          if (start_ok) begin
            state_q    <= S_RUN;
            oBUSY      <= 1'b1;
            stage_q    <= iSTAGE;
            oBANK      <= iSTAGE[0];
            j_q        <= j_d;
            oRD_ADDR_0 <= x0_d;
            oRD_ADDR_1 <= x1_d;
            oRD_ADDR_2 <= x2_d;
            oROM_ADDR  <= rom_d;
          end
        end
        S_RUN: begin
          if (j_q == J_LAST) begin
            state_q <= S_FLUSH;
            flush_q <= '0;
          end else begin
            j_q        <= j_d;
            oRD_ADDR_0 <= x0_d;
            oRD_ADDR_1 <= x1_d;
            oRD_ADDR_2 <= x2_d;
            oROM_ADDR  <= rom_d;
          end
        end
        S_FLUSH: begin
          flush_q <= flush_q + 1'b1;
          if (flush_q == 2'd3) begin
            state_q <= S_DONE;
            oDONE   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          oDONE   <= 1'b0;
          oBUSY   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
